// File: rtl/bin_decode_sequencer.sv
// Bin decode sequencer: splits syntax-element commands into per-cycle
// Decoder operations and schedules bitstream byte insertion.
module bin_decode_sequencer #(
    parameter int BIN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [7:0]           cmd_pstate,
    input  logic                 cmd_bypass,
    input  logic [6:0]           cmd_numbins,
    output logic                 cmd_ready,
    input  logic [2:0]           numBits,
    input  logic                 mps_renorm,
    input  logic                 lps,
    input  logic [BIN_WIDTH-1:0] bin,
    input  logic [7:0]           byte_data,
    input  logic                 byte_valid,
    output logic                 byte_req,
    output logic                 dec_en,
    output logic                 dec_bypass,
    output logic [7:0]           dec_pstate,
    output logic [3:0]           byte_shift,
    output logic                 byte_to_ep,
    output logic                 bin_valid,
    output logic [BIN_WIDTH-1:0] bin_data,
    output logic [2:0]           bin_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t               state_q, state_d;
    logic [6:0]           remain_q, remain_d;
    logic signed [3:0]    bits_needed_q, bits_needed_d;
    logic [7:0]           pstate_q, pstate_d;
    logic                 bypass_q, bypass_d;

    logic [2:0]           n;
    logic signed [3:0]    opnd;
    logic signed [3:0]    sum;
    logic                 upd;
    logic                 need;
    logic [BIN_WIDTH-1:0] mask;

    // byte_data itself is consumed by the Decoder datapath, not here
    logic unused_ok;
    assign unused_ok = ^byte_data;

    assign dec_bypass = bypass_q;
    assign dec_pstate = pstate_q;

    // Per-cycle bin count, bit accounting and byte demand
    always_comb begin
        mask = '0;
        if (!bypass_q)
            n = 3'd1;
        else if (remain_q < 7'(BIN_WIDTH))
            n = remain_q[2:0];
        else
            n = 3'(BIN_WIDTH);
        opnd = bypass_q ? {1'b0, n} : {1'b0, numBits};
        sum  = bits_needed_q + opnd;
        upd  = bypass_q | lps | ~mps_renorm;
        need = ~sum[3] & upd;
        for (int i = 0; i < BIN_WIDTH; i++)
            mask[i] = (3'(i) < n);
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        bits_needed_d = bits_needed_q;
        pstate_d      = pstate_q;
        bypass_d      = bypass_q;
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        dec_en        = 1'b0;
        byte_req      = 1'b0;
        byte_to_ep    = 1'b0;
        byte_shift    = 4'd0;
        bin_valid     = 1'b0;
        bin_cnt       = 3'd0;
        bin_data      = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    pstate_d = cmd_pstate;
                    bypass_d = cmd_bypass;
                    remain_d = cmd_numbins;
                    if (cmd_numbins != 7'd0)
                        state_d = RUN;
                end
            end
            RUN, STALL: begin
                busy       = 1'b1;
                byte_shift = sum;
                if (!need || byte_valid) begin
                    dec_en    = 1'b1;
                    bin_valid = 1'b1;
                    bin_cnt   = n;
                    bin_data  = bin & mask;
                    remain_d  = remain_q - 7'(n);
                    if (need) begin
                        byte_req   = 1'b1;
                        byte_to_ep = (bits_needed_q == -4'sd1);
                        // sum is 0..6 here, so sum-8 just sets the sign bit
                        bits_needed_d = {1'b1, sum[2:0]};
                    end else if (upd) begin
                        bits_needed_d = sum;
                    end
                    state_d = (remain_d == 7'd0) ? IDLE : RUN;
                end else begin
                    state_d = STALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; bits_needed survives across commands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            remain_q      <= 7'd0;
            bits_needed_q <= 4'b1000;
            pstate_q      <= 8'd0;
            bypass_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            bits_needed_q <= bits_needed_d;
            pstate_q      <= pstate_d;
            bypass_q      <= bypass_d;
        end
    end

endmodule
